spi_master_ctrl: RTL and testbench

SPI master transaction controller that sequences the 8-bit MSB-first PISO transmit shifter. It accepts bytes over a valid/ready interface, frames them with chip-select setup/hold/gap timing, and drives the PISO `load` and `shift_en` strobes. It gates SCLK for exactly eight bit-cycles per byte and deserialises MISO into received bytes. The block sits between the host-side command logic and the PISO/pad layer, in the SCLK (`clk`) domain.

---
 rtl/spi_master_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
//
// Purpose:
//   Transaction sequencer for an SPI master. It sits between host-side command
//   logic and an external 8-bit MSB-first PISO shifter plus pad layer. It
//   accepts bytes over a valid/ready port and frames them with chip-select
//   setup/hold/gap timing. It strobes the PISO load/shift controls, gates
//   SCLK for exactly eight bit-cycles per byte, and collects MISO into bytes.
//
// Parameters:
//   CS_SETUP  cycles cs_n is low before the first LOAD      (1..15)
//   CS_HOLD   cycles cs_n stays low after the last bit      (1..15)
//   CS_GAP    minimum cycles cs_n is high between frames    (1..15)
//
// Ports:
//   clk, rst            SCLK-domain clock, asynchronous active-high reset
//   tx_data/tx_last     byte to send and end-of-transaction marker
//   tx_valid/tx_ready   byte handshake
//   rx_data/rx_valid    last received MISO byte, one-cycle update pulse
//   busy                high whenever the FSM is not IDLE
//   piso_data           byte presented to the PISO data input
//   piso_load           PISO parallel-load strobe
//   piso_shift_en       PISO shift enable
//   miso                serial input, sampled on the rising clk edge
//   cs_n                active-low chip select
//   sclk_en             SCLK gate to the pad, high only while shifting
// ---------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int unsigned CS_SETUP = 1,
    parameter int unsigned CS_HOLD  = 1,
    parameter int unsigned CS_GAP   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic [7:0] piso_data,
    output logic       piso_load,
    output logic       piso_shift_en,
    input  logic       miso,
    output logic       cs_n,
    output logic       sclk_en
);

    // The timer counts down to zero, so each timed state lasts (value + 1) cycles.
    localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD - 1);
    localparam logic [3:0] GAP_LAST   = 4'(CS_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_WAIT  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_GAP   = 3'd6
    } state_t;

    state_t     state_q,    state_d;
    logic [3:0] timer_q,    timer_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] tx_byte_q,  tx_byte_d;
    logic       last_q,     last_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q,  rx_data_d;
    logic       rx_valid_q, rx_valid_d;

    logic       last_bit;
    logic       accept;

    // Handshake: a byte transfers on a rising clk edge where tx_valid and
    // tx_ready are both high. tx_ready is decoded from registered state only,
    // so the requester may hold tx_valid high for as long as it likes; the byte
    // is consumed only on the edge where both are high.
    assign last_bit = (bit_cnt_q == 3'd7);
    assign tx_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT) ||
                      ((state_q == ST_SHIFT) && last_bit && !last_q);
    assign accept   = tx_valid && tx_ready;

    assign cs_n          = (state_q == ST_IDLE) || (state_q == ST_GAP);
    assign sclk_en       = (state_q == ST_SHIFT);
    assign piso_load     = (state_q == ST_LOAD);
    // The PISO already shows bit 7 after LOAD, so the last bit needs no shift.
    assign piso_shift_en = (state_q == ST_SHIFT) && !last_bit;
    assign busy          = (state_q != ST_IDLE);
    assign piso_data     = tx_byte_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= 4'd0;
            bit_cnt_q  <= 3'd0;
            tx_byte_q  <= 8'h00;
            last_q     <= 1'b0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_byte_q  <= tx_byte_d;
            last_q     <= last_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        tx_byte_d  = tx_byte_q;
        last_d     = last_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tx_byte_d = tx_data;
                    last_d    = tx_last;
                    timer_d   = SETUP_LAST;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (timer_q == 4'd0) begin
                    state_d = ST_LOAD;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            ST_LOAD: begin
                bit_cnt_d = 3'd0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                rx_shift_d = {rx_shift_q[6:0], miso};
                if (last_bit) begin
                    rx_data_d  = {rx_shift_q[6:0], miso};
                    rx_valid_d = 1'b1;
                    if (last_q) begin
                        timer_d = HOLD_LAST;
                        state_d = ST_HOLD;
                    end else if (accept) begin
                        // Back-to-back byte: only the LOAD cycle separates bytes.
                        tx_byte_d = tx_data;
                        last_d    = tx_last;
                        state_d   = ST_LOAD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            ST_WAIT: begin
                if (accept) begin
                    tx_byte_d = tx_data;
                    last_d    = tx_last;
                    state_d   = ST_LOAD;
                end
            end
            ST_HOLD: begin
                if (timer_q == 4'd0) begin
                    timer_d = GAP_LAST;
                    state_d = ST_GAP;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            ST_GAP: begin
                if (timer_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_master_ctrl
//
// Two controllers run side by side: u[0] with default timing (1/1/2) and
// u[1] with CS_SETUP=3, CS_HOLD=2, CS_GAP=4. Each has its own PISO model
// with MISO looped back to MOSI. Its driver pushes the expected response
// of every accepted byte into queues. A separate monitor pops and compares
// whenever the DUT pulses rx_valid or toggles cs_n.
//
// Timing model (cycle a = the cycle whose closing edge accepts a byte):
//   first byte of a frame : cs_n falls a+1, rx_valid at a+S+10
//   later byte            : LOAD at a+1,    rx_valid at a+10
//   last byte, rx at v    : cs_n rises at v+H, next accept possible at v+H+G
//   non-last byte         : next byte accepted at max(presented, k7 cycle)
// ---------------------------------------------------------------------------
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, int act, int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp_v, exp_v, cyc);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int S = (g == 0) ? 1 : 3;
    localparam int H = (g == 0) ? 1 : 2;
    localparam int G = (g == 0) ? 2 : 4;

    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic [7:0] piso_data;
    logic       piso_load;
    logic       piso_shift_en;
    logic       miso;
    logic       cs_n;
    logic       sclk_en;

    logic [7:0] piso_sh = 8'h00;
    bit         done_r = 1'b0;

    // scoreboard queues
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    bit         exp_last_q[$];
    int         fall_q[$];
    int         rise_q[$];

    // driver-side reference state
    int ready_at = 0;
    bit in_txn = 1'b0;
    int last_acc = 0;

    // monitor-side state
    bit         prev_cs = 1'b1;
    int         sclk_cnt = 0;
    int         sh_cnt = 0;
    int         load_cyc = 0;
    logic [7:0] load_d = 8'h00;
    logic [7:0] mosi_b = 8'h00;

    spi_master_ctrl #(.CS_SETUP(S), .CS_HOLD(H), .CS_GAP(G)) dut (
      .clk(clk), .rst(rst),
      .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .piso_data(piso_data), .piso_load(piso_load), .piso_shift_en(piso_shift_en),
      .miso(miso), .cs_n(cs_n), .sclk_en(sclk_en)
    );

    // PISO model: MSB first, loaded in parallel, MISO looped back to MOSI.
    always @(posedge clk) begin
      if (piso_load) piso_sh <= piso_data;
      else if (piso_shift_en) piso_sh <= {piso_sh[6:0], 1'b0};
    end
    assign miso = piso_sh[7];

    function automatic void chk(string nm, int act, int exp_v);
      check($sformatf("u%0d.%s", g, nm), act, exp_v);
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send_byte(input logic [7:0] d, input bit last, input int delay);
      int n;
      int p;
      int a;
      int exp_a;
      bit first;
      for (int i = 0; i < delay; i++) begin
        tx_valid = 1'b0;
        if (in_txn && cyc > ready_at) begin
          chk("wait_cs_n", cs_n, 0);
          chk("wait_sclk_en", sclk_en, 0);
          chk("wait_tx_ready", tx_ready, 1);
        end
        @(negedge clk);
      end
      tx_valid = 1'b1;
      tx_data  = d;
      tx_last  = last;
      p = cyc;
      n = 0;
      while (!tx_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (!tx_ready) begin
        chk("accept_timeout", 0, 1);
        tx_valid = 1'b0;
        return;
      end
      a = cyc;
      first = !in_txn;
      exp_a = (p > ready_at) ? p : ready_at;
      chk("accept_cycle", a, exp_a);
      exp_q.push_back(d);
      exp_cyc_q.push_back(a + (first ? S : 0) + 10);
      exp_last_q.push_back(last);
      if (first) fall_q.push_back(a + 1);
      if (last) begin
        ready_at = a + (first ? S : 0) + 10 + H + G;
        in_txn = 1'b0;
      end else begin
        ready_at = a + (first ? S : 0) + 9;
        in_txn = 1'b1;
      end
      last_acc = a;
      @(negedge clk);
      tx_valid = 1'b0;
    endtask

    // monitor
    always @(negedge clk) begin : mon
      logic [7:0] d;
      int v;
      bit l;
      if (rst) begin
        prev_cs  = cs_n;
        sclk_cnt = 0;
        sh_cnt   = 0;
      end else begin
        if (sclk_en) begin
          chk("sclk_cs_n", cs_n, 0);
          sclk_cnt++;
          mosi_b = {mosi_b[6:0], miso};
        end
        if (piso_shift_en) sh_cnt++;
        if (rx_valid) begin
          if (exp_q.size() == 0) begin
            chk("rx_spurious", 1, 0);
          end else begin
            d = exp_q.pop_front();
            v = exp_cyc_q.pop_front();
            l = exp_last_q.pop_front();
            chk("rx_data", rx_data, d);
            chk("rx_cycle", cyc, v);
            chk("mosi_byte", mosi_b, d);
            chk("sclk_count", sclk_cnt, 8);
            chk("shift_en_count", sh_cnt, 7);
            chk("load_cycle", load_cyc, v - 9);
            chk("piso_data", load_d, d);
            if (l) rise_q.push_back(v + H);
          end
          sclk_cnt = 0;
          sh_cnt   = 0;
        end
        if (piso_load) begin
          load_cyc = cyc;
          load_d   = piso_data;
        end
        if (prev_cs && !cs_n) begin
          if (fall_q.size() == 0) chk("cs_fall_spurious", 1, 0);
          else chk("cs_fall_cycle", cyc, fall_q.pop_front());
        end
        if (!prev_cs && cs_n) begin
          if (rise_q.size() == 0) chk("cs_rise_spurious", 1, 0);
          else chk("cs_rise_cycle", cyc, rise_q.pop_front());
        end
        prev_cs = cs_n;
      end
    end

    initial begin : stim
      int nb;
      int dly;
      int n;
      int tgt;
      // reset, with a byte offered that must not be taken
      tx_valid = 1'b1;
      tx_data  = 8'h99;
      tx_last  = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_sclk_en", sclk_en, 0);
      chk("rst_piso_load", piso_load, 0);
      chk("rst_piso_shift_en", piso_shift_en, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_piso_data", piso_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_ready", tx_ready, 1);
      tx_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);

      // single byte
      send_byte(8'hA5, 1'b1, 0);
      // burst with tx_valid held
      send_byte(8'h3C, 1'b0, 0);
      send_byte(8'hFF, 1'b0, 0);
      send_byte(8'h01, 1'b1, 0);
      // stall: second byte presented 5 cycles after its slot
      send_byte(8'h11, 1'b0, 2);
      send_byte(8'h22, 1'b0, ready_at - cyc + 5);
      send_byte(8'h33, 1'b1, 0);

      // reset during SHIFT k=3
      send_byte(8'hC3, 1'b1, 0);
      tgt = last_acc + S + 5;
      while (cyc < tgt) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_cs_n", cs_n, 1);
      chk("midrst_sclk_en", sclk_en, 0);
      chk("midrst_shift_en", piso_shift_en, 0);
      chk("midrst_busy", busy, 0);
      exp_q.delete();
      exp_cyc_q.delete();
      exp_last_q.delete();
      fall_q.delete();
      rise_q.delete();
      in_txn = 1'b0;
      ready_at = 0;
      @(negedge clk);
      chk("midrst_rx_valid", rx_valid, 0);
      chk("midrst_rx_data", rx_data, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("midrst_idle", busy, 0);
      send_byte(8'h5A, 1'b1, 0);

      // back-to-back single-byte transactions
      send_byte(8'h81, 1'b1, 0);
      send_byte(8'h7E, 1'b1, 0);

      // randomized frames
      for (int t = 0; t < 25; t++) begin
        nb = $urandom_range(1, 4);
        for (int b = 0; b < nb; b++) begin
          dly = (b == 0) ? $urandom_range(0, 5) : $urandom_range(0, 3);
          send_byte(8'($urandom), (b == nb - 1), dly);
        end
      end

      // drain
      n = 0;
      while ((exp_q.size() + fall_q.size() + rise_q.size()) != 0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("drain_left", exp_q.size() + fall_q.size() + rise_q.size(), 0);
      repeat (4) @(negedge clk);
      done_r = 1'b1;
    end
  end

  initial begin : finisher
    int n;
    n = 0;
    while (!(u[0].done_r && u[1].done_r) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (!(u[0].done_r && u[1].done_r)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL watchdog: bench not done after %0d cycles, expected completion", n);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
